// File: rtl/img_pkg.sv
// img_pkg: frame constants and state encoding shared by the white-balance
// pipeline stages (frame_loader and the processing stage).
package img_pkg;
  localparam int PIXELS = 76800;  // 320x240
  localparam int ADDR_W = 17;

  typedef enum logic [1:0] {
    RX      = 2'd0,  // receiving bytes into frame memory
    PROC    = 2'd1,  // active=1, processing stage owns frame memory
    RELEASE = 2'd2   // waiting for done to drop before re-arming
  } loader_state_t;
endpackage

// File: rtl/frame_idle_timer.sv
// frame_idle_timer: counts idle cycles of a partially received frame.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   i_run        count enable (loader in RX with a partial frame)
//   i_strobe     byte strobe; clears the count and suppresses expiry
//   o_expire     combinational: count at TIMEOUT_CYCLES-1 with no strobe
module frame_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_strobe,
  output logic o_expire
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // A strobe in the expiry cycle wins, so expiry is gated by !i_strobe.
  assign o_expire = i_run && !i_strobe && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst || i_strobe || !i_run || o_expire) r_cnt <= '0;
    else                                        r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/frame_loader.sv
// frame_loader: packs a serial R,G,B byte stream into pixels, writes them to
// frame memory at 0..PIXELS-1, then runs the active/done level handshake
// with the processing stage and re-arms.
// Optional feature: define FRAME_LOADER_TIMEOUT_EN to discard a partial frame
// after TIMEOUT_CYCLES idle cycles (pulses frame_timeout).
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   byte_in/byte_valid               received byte and its one-cycle strobe
//   byte_ready                       high while bytes are accepted (RX)
//   byte_drop                        pulse: strobe arrived outside RX
//   we/addr_write/red,green,blue_out frame-memory write port
//   active/done                      handshake with processing stage
//   frame_timeout                    pulse: partial frame discarded
// All outputs are registered.
module frame_loader
  import img_pkg::*;
#(
  parameter int PIXELS = img_pkg::PIXELS,
  parameter int ADDR_W = img_pkg::ADDR_W
`ifdef FRAME_LOADER_TIMEOUT_EN
 ,parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              byte_drop,
  output logic              we,
  output logic [ADDR_W-1:0] addr_write,
  output logic [7:0]        red_out,
  output logic [7:0]        green_out,
  output logic [7:0]        blue_out,
  output logic              active,
  input  logic              done,
  output logic              frame_timeout
);
  loader_state_t     r_state, w_state_nxt;
  logic [1:0]        r_byte_idx;
  logic [ADDR_W-1:0] r_pix_cnt;
  logic [7:0]        r_red_stg, r_green_stg;
  logic              r_byte_ready, r_byte_drop, r_we, r_active, r_frame_timeout;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_red, r_green, r_blue;

  logic w_accept, w_last_pix, w_expire;
  logic w_ready_nxt, w_active_nxt;

  assign w_accept   = byte_valid && (r_state == RX);
  assign w_last_pix = (r_byte_idx == 2'd2) && (r_pix_cnt == ADDR_W'(PIXELS - 1));

`ifdef FRAME_LOADER_TIMEOUT_EN
  logic w_run;
  assign w_run = (r_state == RX) && ((r_pix_cnt != '0) || (r_byte_idx != 2'd0));

  frame_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk      (clk),
    .rst      (rst),
    .i_run    (w_run),
    .i_strobe (byte_valid),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= RX;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; done in RX is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX:      if (w_accept && w_last_pix) w_state_nxt = PROC;
      PROC:    if (done)                   w_state_nxt = RELEASE;
      RELEASE: if (!done)                  w_state_nxt = RX;
      default:                             w_state_nxt = RX;
    endcase
  end

  // Output decode, registered below. active is driven from the current
  // state so it rises one cycle after the last write (never overlaps we),
  // and drops the cycle after done is seen.
  always_comb begin
    w_ready_nxt  = (w_state_nxt == RX);
    w_active_nxt = (r_state == PROC) && (w_state_nxt == PROC);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_byte_idx      <= 2'd0;
      r_pix_cnt       <= '0;
      r_red_stg       <= '0;
      r_green_stg     <= '0;
      r_byte_ready    <= 1'b1;
      r_byte_drop     <= 1'b0;
      r_we            <= 1'b0;
      r_addr          <= '0;
      r_red           <= '0;
      r_green         <= '0;
      r_blue          <= '0;
      r_active        <= 1'b0;
      r_frame_timeout <= 1'b0;
    end else begin
      r_we            <= 1'b0;
      r_byte_drop     <= 1'b0;
      r_frame_timeout <= 1'b0;
      r_byte_ready    <= w_ready_nxt;
      r_active        <= w_active_nxt;
      if (byte_valid && !w_accept) begin
        r_byte_drop <= 1'b1;
      end else if (w_accept) begin
        case (r_byte_idx)
          2'd0: begin
            r_red_stg  <= byte_in;
            r_byte_idx <= 2'd1;
          end
          2'd1: begin
            r_green_stg <= byte_in;
            r_byte_idx  <= 2'd2;
          end
          2'd2: begin
            r_we       <= 1'b1;
            r_addr     <= r_pix_cnt;
            r_red      <= r_red_stg;
            r_green    <= r_green_stg;
            r_blue     <= byte_in;
            r_byte_idx <= 2'd0;
            r_pix_cnt  <= w_last_pix ? '0 : r_pix_cnt + 1'b1;
          end
          default: r_byte_idx <= 2'd0;
        endcase
      end else if (w_expire) begin
        r_pix_cnt       <= '0;
        r_byte_idx      <= 2'd0;
        r_frame_timeout <= 1'b1;
      end
    end
  end

  assign byte_ready    = r_byte_ready;
  assign byte_drop     = r_byte_drop;
  assign we            = r_we;
  assign addr_write    = r_addr;
  assign red_out       = r_red;
  assign green_out     = r_green;
  assign blue_out      = r_blue;
  assign active        = r_active;
  assign frame_timeout = r_frame_timeout;
endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader with PIXELS=4 (and TIMEOUT_CYCLES=8 when
// FRAME_LOADER_TIMEOUT_EN is defined).
module tb_frame_loader;
  localparam int PIX = 4;
  localparam int AW  = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready, byte_drop, we, active, frame_timeout;
  logic          done = 1'b0;
  logic [AW-1:0] addr_write;
  logic [7:0]    red_out, green_out, blue_out;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] wq_addr[$];
  logic [23:0]   wq_data[$];

  always #5 clk = ~clk;

  frame_loader #(
    .PIXELS(PIX),
    .ADDR_W(AW)
`ifdef FRAME_LOADER_TIMEOUT_EN
   ,.TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .byte_drop     (byte_drop),
    .we            (we),
    .addr_write    (addr_write),
    .red_out       (red_out),
    .green_out     (green_out),
    .blue_out      (blue_out),
    .active        (active),
    .done          (done),
    .frame_timeout (frame_timeout)
  );

  // Write log, sampled on the inactive edge.
  always @(negedge clk) begin
    if (we) begin
      wq_addr.push_back(addr_write);
      wq_data.push_back({red_out, green_out, blue_out});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; byte_valid = 1'b0; done = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    wq_addr.delete(); wq_data.delete();
  endtask

  // Drive one byte per cycle; returns just after the edge sampling the last one.
  task automatic send(input logic [7:0] b);
    byte_in = b; byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; byte_valid = 1'b0; done = 1'b0;
    repeat (3) tick();
    total++;
    if ({we, byte_drop, active, frame_timeout} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctl got we/drop/act/to=%b want 0000",
                      {we, byte_drop, active, frame_timeout});
    end
    total++;
    if (byte_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got %b want 1", byte_ready);
    end
    total++;
    if ({addr_write, red_out, green_out, blue_out} !== '0) begin
      bad++; $display("FAIL reset_data got addr=%0h rgb=%h%h%h want 0",
                      addr_write, red_out, green_out, blue_out);
    end
    rst = 1'b1;
    wq_addr.delete(); wq_data.delete();
  endtask

  task automatic test_single_pixel();
    do_reset();
    send(8'h10); send(8'h20);
    total++;
    if (we !== 1'b0) begin bad++; $display("FAIL sp_early_we got %b want 0", we); end
    send(8'h30);
    total++;
    if (we !== 1'b1 || addr_write !== 17'd0 || {red_out, green_out, blue_out} !== 24'h102030) begin
      bad++; $display("FAIL sp_write got we=%b addr=%0d rgb=%h%h%h want 1/0/102030",
                      we, addr_write, red_out, green_out, blue_out);
    end
    tick();
    total++;
    if (we !== 1'b0 || addr_write !== 17'd0 || {red_out, green_out, blue_out} !== 24'h102030) begin
      bad++; $display("FAIL sp_hold got we=%b addr=%0d rgb=%h%h%h want 0/0/102030",
                      we, addr_write, red_out, green_out, blue_out);
    end
    total++;
    if (wq_addr.size() != 1) begin bad++; $display("FAIL sp_count got %0d want 1", wq_addr.size()); end
  endtask

  task automatic test_full_frame();
    do_reset();
    for (int i = 0; i < 12; i++) send(8'h40 + 8'(i));
    total++;
    if (we !== 1'b1 || active !== 1'b0 || addr_write !== 17'd3) begin
      bad++; $display("FAIL ff_last got we=%b act=%b addr=%0d want 1/0/3", we, active, addr_write);
    end
    tick();
    total++;
    if (we !== 1'b0 || active !== 1'b1 || byte_ready !== 1'b0) begin
      bad++; $display("FAIL ff_active got we=%b act=%b rdy=%b want 0/1/0", we, active, byte_ready);
    end
    total++;
    if (wq_addr.size() != 4) begin
      bad++; $display("FAIL ff_count got %0d want 4", wq_addr.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        logic [23:0] exp;
        exp = {8'h40 + 8'(3*k), 8'h41 + 8'(3*k), 8'h42 + 8'(3*k)};
        total++;
        if (wq_addr[k] !== 17'(k) || wq_data[k] !== exp) begin
          bad++; $display("FAIL ff_pix%0d got addr=%0d rgb=%h want %0d/%h",
                          k, wq_addr[k], wq_data[k], k, exp);
        end
      end
    end
  endtask

  // Continues from the PROC state left by test_full_frame.
  task automatic test_handshake_drop();
    wq_addr.delete(); wq_data.delete();
    send(8'hEE);
    total++;
    if (byte_drop !== 1'b1 || we !== 1'b0 || active !== 1'b1) begin
      bad++; $display("FAIL hs_drop got drop=%b we=%b act=%b want 1/0/1", byte_drop, we, active);
    end
    tick();
    total++;
    if (byte_drop !== 1'b0) begin bad++; $display("FAIL hs_drop_pulse got %b want 0", byte_drop); end
    done = 1'b1;
    total++;
    if (active !== 1'b1) begin bad++; $display("FAIL hs_pre_done got act=%b want 1", active); end
    tick();
    total++;
    if (active !== 1'b0 || byte_ready !== 1'b0) begin
      bad++; $display("FAIL hs_done got act=%b rdy=%b want 0/0", active, byte_ready);
    end
    tick(); tick();
    total++;
    if (active !== 1'b0 || byte_ready !== 1'b0) begin
      bad++; $display("FAIL hs_release got act=%b rdy=%b want 0/0", active, byte_ready);
    end
    done = 1'b0;
    tick();
    total++;
    if (byte_ready !== 1'b1) begin bad++; $display("FAIL hs_rearm got rdy=%b want 1", byte_ready); end
    send(8'h01); send(8'h02); send(8'h03);
    total++;
    if (we !== 1'b1 || addr_write !== 17'd0 || {red_out, green_out, blue_out} !== 24'h010203) begin
      bad++; $display("FAIL hs_next got we=%b addr=%0d rgb=%h%h%h want 1/0/010203",
                      we, addr_write, red_out, green_out, blue_out);
    end
    total++;
    if (wq_addr.size() != 0) begin bad++; $display("FAIL hs_stray_we got %0d writes want 0", wq_addr.size()); end
  endtask

  task automatic test_done_in_rx();
    do_reset();
    done = 1'b1;
    send(8'h11); send(8'h22); send(8'h33);
    total++;
    if (we !== 1'b1 || addr_write !== 17'd0 || active !== 1'b0 || byte_ready !== 1'b1) begin
      bad++; $display("FAIL rx_done got we=%b addr=%0d act=%b rdy=%b want 1/0/0/1",
                      we, addr_write, active, byte_ready);
    end
    done = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i));
    do_reset();
    send(8'hA1); send(8'hA2); send(8'hA3);
    total++;
    if (we !== 1'b1 || addr_write !== 17'd0 || {red_out, green_out, blue_out} !== 24'hA1A2A3) begin
      bad++; $display("FAIL mr_write got we=%b addr=%0d rgb=%h%h%h want 1/0/a1a2a3",
                      we, addr_write, red_out, green_out, blue_out);
    end
  endtask

  task automatic test_timeout();
    int first, width;
    do_reset();
    for (int i = 0; i < 4; i++) send(8'h60 + 8'(i));
    first = 0; width = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (frame_timeout === 1'b1) begin
        if (first == 0) first = i;
        width++;
      end
    end
`ifdef FRAME_LOADER_TIMEOUT_EN
    total++;
    if (first != 8 || width != 1) begin
      bad++; $display("FAIL to_pulse got first=%0d width=%0d want 8/1", first, width);
    end
    send(8'h71); send(8'h72); send(8'h73);
    total++;
    if (we !== 1'b1 || addr_write !== 17'd0 || {red_out, green_out, blue_out} !== 24'h717273) begin
      bad++; $display("FAIL to_restart got we=%b addr=%0d rgb=%h%h%h want 1/0/717273",
                      we, addr_write, red_out, green_out, blue_out);
    end
`else
    total++;
    if (width != 0) begin bad++; $display("FAIL to_none got %0d pulses want 0", width); end
    send(8'h71); send(8'h72);
    total++;
    if (we !== 1'b1 || addr_write !== 17'd1 || {red_out, green_out, blue_out} !== 24'h637172) begin
      bad++; $display("FAIL to_resume got we=%b addr=%0d rgb=%h%h%h want 1/1/637172",
                      we, addr_write, red_out, green_out, blue_out);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_full_frame();
    test_handshake_drop();
    test_done_in_rx();
    test_mid_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
